// File: rtl/seven_seg_pkg.sv
// Shared constants for the seven-segment scan controller: segment table,
// blank pattern, FSM state encoding and output polarity helper.
package seven_seg_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_e;

    localparam logic [6:0] SEG_BLANK = 7'h00;

    // Active-high {g,f,e,d,c,b,a} patterns for nibbles 0..F
    localparam logic [6:0] HEX_SEG [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    function automatic logic [6:0] seg_polarity(input logic [6:0] value, input bit active_low);
        return active_low ? ~value : value;
    endfunction

endpackage

// File: rtl/hex_to_seg.sv
// Combinational nibble to active-high seven-segment decoder with blank override.
module hex_to_seg
    import seven_seg_pkg::*;
(
    input  logic [3:0] nib_i,
    input  logic       blank_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = blank_i ? SEG_BLANK : HEX_SEG[nib_i];
    end

endmodule

// File: rtl/seven_seg_scan_controller.sv
// Time-multiplexed seven-segment controller: per-frame register snapshot,
// digit scanning with optional leading-zero blanking, static decoded bus.
module seven_seg_scan_controller
    import seven_seg_pkg::*;
#(
    parameter int NUM_REGS    = 8,
    parameter int DATA_W      = 16,
    parameter int REFRESH_DIV = 50000,
    parameter int ACTIVE_LOW  = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          enable,
    input  logic [$clog2(NUM_REGS)-1:0]   sw,
    input  logic [NUM_REGS*DATA_W-1:0]    regs,
    input  logic                          blank_lz,
    output logic [6:0]                    seg,
    output logic [DATA_W/4-1:0]           an,
    output logic [(DATA_W/4)*7-1:0]       displ,
    output logic                          frame_done
);

    localparam int NUM_DIGITS = DATA_W / 4;
    localparam int SEL_W      = $clog2(NUM_REGS);
    localparam int PS_W       = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IDX_W      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam bit POL_LOW    = (ACTIVE_LOW != 0);

    localparam logic [6:0]            SEG_OFF  = seg_polarity(SEG_BLANK, POL_LOW);
    localparam logic [NUM_DIGITS-1:0] AN_OFF   = POL_LOW ? '1 : '0;
    localparam logic [PS_W-1:0]       PS_LAST  = PS_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0]      IDX_LAST = IDX_W'(NUM_DIGITS - 1);

    state_e                   state_q, state_d;
    logic [PS_W-1:0]          ps_q, ps_d;
    logic [IDX_W-1:0]         idx_q, idx_d;
    logic [DATA_W-1:0]        shadow_q, shadow_d;
    logic                     fd_d;
    logic [DATA_W-1:0]        sel_val;
    logic [NUM_DIGITS-1:0]    blank_dig;
    logic [6:0]               raw_seg [NUM_DIGITS];
    logic [NUM_DIGITS*7-1:0]  displ_d;
    logic [6:0]               seg_d;
    logic [NUM_DIGITS-1:0]    an_d;
    logic                     tick;

    // Out-of-range selects match no register and fall through to zero
    always_comb begin
        sel_val = '0;
        for (int unsigned k = 0; k < NUM_REGS; k++) begin
            if (sw == SEL_W'(k)) sel_val = regs[k*DATA_W +: DATA_W];
        end
    end

    assign tick = (ps_q == PS_LAST);

    always_comb begin
        state_d  = state_q;
        ps_d     = ps_q;
        idx_d    = idx_q;
        shadow_d = shadow_q;
        fd_d     = 1'b0;
        case (state_q)
            IDLE: begin
                ps_d  = '0;
                idx_d = '0;
                if (enable) begin
                    state_d  = SCAN;
                    shadow_d = sel_val;
                end
            end
            SCAN: begin
                if (!enable) begin
                    state_d = IDLE;
                    ps_d    = '0;
                    idx_d   = '0;
                end else if (tick) begin
                    ps_d = '0;
                    if (idx_q == IDX_LAST) begin
                        idx_d    = '0;
                        shadow_d = sel_val;
                        fd_d     = 1'b1;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end else begin
                    ps_d = ps_q + PS_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs decode the next-state snapshot so they land on the same edge
    always_comb begin
        logic nz_above;
        nz_above  = 1'b0;
        blank_dig = '0;
        for (int unsigned j = 0; j < NUM_DIGITS; j++) begin
            nz_above = nz_above | (|shadow_d[(NUM_DIGITS-1-j)*4 +: 4]);
            if (j != NUM_DIGITS - 1) blank_dig[NUM_DIGITS-1-j] = blank_lz && !nz_above;
        end
    end

    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dec
        hex_to_seg u_dec (
            .nib_i   (shadow_d[g*4 +: 4]),
            .blank_i (blank_dig[g]),
            .seg_o   (raw_seg[g])
        );
    end

    always_comb begin
        displ_d = '0;
        seg_d   = SEG_OFF;
        an_d    = AN_OFF;
        for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
            displ_d[k*7 +: 7] = seg_polarity(raw_seg[k], POL_LOW);
            if (state_d == SCAN && idx_d == IDX_W'(k)) begin
                seg_d = seg_polarity(raw_seg[k], POL_LOW);
                an_d[k] = !POL_LOW;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            ps_q       <= '0;
            idx_q      <= '0;
            shadow_q   <= '0;
            frame_done <= 1'b0;
            seg        <= SEG_OFF;
            an         <= AN_OFF;
            displ      <= {NUM_DIGITS{SEG_OFF}};
        end else begin
            state_q    <= state_d;
            ps_q       <= ps_d;
            idx_q      <= idx_d;
            shadow_q   <= shadow_d;
            frame_done <= fd_d;
            seg        <= seg_d;
            an         <= an_d;
            displ      <= displ_d;
        end
    end

endmodule

// File: tb/tb_seven_seg_scan_controller.sv
// Directed self-checking bench for seven_seg_scan_controller.
module tb_seven_seg_scan_controller;

    logic         clk;
    logic         rst;
    logic         enable;
    logic [2:0]   sw;
    logic [127:0] regs;
    logic         blank_lz;
    logic [6:0]   seg;
    logic [3:0]   an;
    logic [27:0]  displ;
    logic         frame_done;

    logic         enable6;
    logic [2:0]   sw6;
    logic [95:0]  regs6;
    logic         blank_lz6;
    logic [6:0]   seg6;
    logic [3:0]   an6;
    logic [27:0]  displ6;
    logic         frame_done6;

    int checks = 0;
    int errors = 0;

    seven_seg_scan_controller #(
        .NUM_REGS(8), .DATA_W(16), .REFRESH_DIV(4), .ACTIVE_LOW(1)
    ) u_dut (
        .clk(clk), .rst(rst), .enable(enable), .sw(sw), .regs(regs),
        .blank_lz(blank_lz), .seg(seg), .an(an), .displ(displ),
        .frame_done(frame_done)
    );

    seven_seg_scan_controller #(
        .NUM_REGS(6), .DATA_W(16), .REFRESH_DIV(1), .ACTIVE_LOW(1)
    ) u_dut6 (
        .clk(clk), .rst(rst), .enable(enable6), .sw(sw6), .regs(regs6),
        .blank_lz(blank_lz6), .seg(seg6), .an(an6), .displ(displ6),
        .frame_done(frame_done6)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Hand-computed inverted patterns, index = digit position
    logic [6:0] e1234 [4] = '{7'h19, 7'h30, 7'h24, 7'h79};
    logic [6:0] eabcd [4] = '{7'h21, 7'h46, 7'h03, 7'h08};
    logic [6:0] e0005 [4] = '{7'h12, 7'h7F, 7'h7F, 7'h7F};
    logic [6:0] e0000 [4] = '{7'h40, 7'h7F, 7'h7F, 7'h7F};

    initial begin
        logic [3:0] exp_an;
        logic [6:0] exp_seg;
        int d;

        rst = 1'b1; enable = 1'b0; sw = 3'd1; blank_lz = 1'b0;
        regs = '0;
        regs[0*16 +: 16] = 16'hDEAD;
        regs[1*16 +: 16] = 16'h1234;
        regs[2*16 +: 16] = 16'hABCD;
        regs[3*16 +: 16] = 16'h0005;
        regs[4*16 +: 16] = 16'h0000;
        regs[5*16 +: 16] = 16'h5555;
        regs[6*16 +: 16] = 16'h6666;
        regs[7*16 +: 16] = 16'h7777;
        enable6 = 1'b0; sw6 = 3'd7; blank_lz6 = 1'b0;
        regs6 = {16'h6666, 16'h5555, 16'h4444, 16'h3333, 16'h2222, 16'h1111};

        // Reset state, held for several cycles
        for (int i = 0; i < 4; i++) begin
            step();
            check("rst_an", an, 4'b1111);
            check("rst_seg", seg, 7'h7F);
            check("rst_displ", displ, {4{7'h7F}});
            check("rst_fd", frame_done, 1'b0);
        end
        rst = 1'b0;
        step();
        check("idle_an", an, 4'b1111);
        check("idle_seg", seg, 7'h7F);

        // Out-of-range select on 6-register instance, REFRESH_DIV=1
        enable6 = 1'b1;
        for (int k = 0; k <= 8; k++) begin
            step();
            exp_an = ~(4'b0001 << (k % 4));
            check("r6_an", an6, exp_an);
            check("r6_fd", frame_done6, (k > 0 && k % 4 == 0));
            check("r6_seg", seg6, 7'h40);
            check("r6_displ", displ6, {4{7'h40}});
        end
        enable6 = 1'b0;

        // Frame scan of reg1, mid-frame switch to reg2
        enable = 1'b1;
        step();
        check("e0_an", an, 4'b1110);
        check("e0_seg", seg, 7'h19);
        check("e0_displ", displ, {7'h79, 7'h24, 7'h30, 7'h19});
        check("e0_fd", frame_done, 1'b0);
        for (int c = 1; c <= 40; c++) begin
            if (c == 6) sw = 3'd2;
            step();
            d = (c / 4) % 4;
            exp_an  = ~(4'b0001 << d);
            exp_seg = (c < 16) ? e1234[d] : eabcd[d];
            check("scan_an", an, exp_an);
            check("scan_seg", seg, exp_seg);
            check("scan_fd", frame_done, (c % 16 == 0));
            if (c == 15) check("keep_displ", displ, {7'h79, 7'h24, 7'h30, 7'h19});
            if (c == 16) check("new_displ", displ, {7'h08, 7'h03, 7'h46, 7'h21});
        end

        // Disable at idx=2: dark, no pulse, snapshot retained
        enable = 1'b0;
        for (int c = 0; c < 9; c++) begin
            step();
            check("off_an", an, 4'b1111);
            check("off_seg", seg, 7'h7F);
            check("off_fd", frame_done, 1'b0);
        end
        check("off_displ", displ, {7'h08, 7'h03, 7'h46, 7'h21});

        // Re-enable with blanking on 0005, then snapshot of 0000
        sw = 3'd3; blank_lz = 1'b1; enable = 1'b1;
        step();
        check("re_an", an, 4'b1110);
        check("re_seg", seg, 7'h12);
        check("lz_displ", displ, {7'h7F, 7'h7F, 7'h7F, 7'h12});
        for (int c = 1; c <= 16; c++) begin
            if (c == 5) sw = 3'd4;
            step();
            d = (c / 4) % 4;
            exp_an  = ~(4'b0001 << d);
            exp_seg = (c < 16) ? e0005[d] : e0000[d];
            check("lz_an", an, exp_an);
            check("lz_seg", seg, exp_seg);
            check("lz_fd", frame_done, (c == 16));
        end
        check("zero_displ", displ, {7'h7F, 7'h7F, 7'h7F, 7'h40});
        blank_lz = 1'b0;
        step();
        check("nolz_displ", displ, {4{7'h40}});
        check("nolz_seg", seg, 7'h40);

        // Asynchronous reset between clock edges
        #3;
        rst = 1'b1;
        #1;
        check("arst_an", an, 4'b1111);
        check("arst_seg", seg, 7'h7F);
        check("arst_displ", displ, {4{7'h7F}});
        check("arst_fd", frame_done, 1'b0);
        check("arst_an6", an6, 4'b1111);
        step();
        rst = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
